// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared types and width helpers for the frequency meter controller
package fm_pkg;

  // Encodings kept as plain constants so older blocks can compare against raw state bits
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DIV  = ST_DIV,
    OUT  = ST_OUT
  } fm_state_e;

  // Default fractional width used by the display/UART consumers of fm_result_t
  localparam int FM_FRAC_DEF = 8;

  typedef struct packed {
    logic [32+FM_FRAC_DEF-1:0] freq_q;
    logic                      no_signal;
    logic                      overrun;
  } fm_result_t;

  // Bits needed to hold the value f, i.e. clog2(f+1)
  function automatic int fm_cw(input longint unsigned f);
    int w;
    w = 0;
    for (int i = 0; i < 63; i++) begin
      if ((longint'(1) << i) <= longint'(f)) w = i + 1;
    end
    return w;
  endfunction

  // Dividend width: 32-bit wave count times the clock constant, plus fraction
  function automatic int fm_dw(input longint unsigned f, input int frac);
    return 32 + fm_cw(f) + frac;
  endfunction

  // Result width: 32 integer bits plus fraction
  function automatic int fm_qw(input int frac);
    return 32 + frac;
  endfunction

endpackage

// File: rtl/fm_divider.sv
// rtl/fm_divider.sv - restoring shift-subtract divider, one quotient bit per cycle
module fm_divider #(
  parameter int DW = 67
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [31:0]   divisor,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int CNW = $clog2(DW + 1);

  logic [DW-1:0]  q_r;
  logic [DW-1:0]  src_q;
  logic [DW-1:0]  q_nx;
  logic [31:0]    r_r;
  logic [31:0]    src_r;
  logic [32:0]    r_sh;
  logic [31:0]    r_nx;
  logic           ge;
  logic [CNW-1:0] cnt;

  // One restoring step; the start cycle already produces the first quotient bit
  always_comb begin
    src_q = start ? dividend : q_r;
    src_r = start ? 32'd0 : r_r;
    r_sh  = {src_r, src_q[DW-1]};
    ge    = (r_sh >= {1'b0, divisor});
    r_nx  = ge ? 32'(r_sh - {1'b0, divisor}) : r_sh[31:0];
    q_nx  = {src_q[DW-2:0], ge};
  end

  // Dividend register doubles as quotient register as bits shift in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r  <= '0;
      r_r  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      q_r  <= q_nx;
      r_r  <= r_nx;
      cnt  <= CNW'(DW - 1);
      done <= (DW == 1);
    end else if (cnt != '0) begin
      q_r  <= q_nx;
      r_r  <= r_nx;
      cnt  <= cnt - 1'b1;
      done <= (cnt == CNW'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = q_r;

endmodule

// File: rtl/fm_ctrl.sv
// rtl/fm_ctrl.sv - capture, divide and deliver dual-counter frequency measurements
import fm_pkg::*;

module fm_ctrl #(
  parameter int unsigned F_CLK_HZ    = 100_000_000,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned TIMEOUT_CYC = 300_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   safe_in,
  input  logic [31:0]            a_in,
  input  logic [31:0]            b_in,
  output logic [31+FRAC_BITS:0]  freq_q,
  output logic                   freq_valid,
  input  logic                   freq_ready,
  output logic                   no_signal,
  output logic                   overrun,
  output logic                   busy
);

  localparam int DW = fm_dw(F_CLK_HZ, FRAC_BITS);
  localparam int QW = fm_qw(FRAC_BITS);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic          safe_m, safe_s;
  logic [31:0]   a_r, b_r, a_p, b_p;
  logic [31:0]   a_last, b_last;
  logic [31:0]   a_cap, b_cap;
  logic [SW-1:0] stab;
  logic [TW-1:0] tcnt;
  logic [1:0]    state;
  logic          ovr_sticky;
  logic          eq, capture, timeout, drop;
  logic          div_start, div_done;
  logic [DW-1:0] dividend, quotient;
  logic [QW-1:0] q_sat;

  // Safe flag synchronizer and per-cycle registering of the raw counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      safe_m <= 1'b0;
      safe_s <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      a_p    <= '0;
      b_p    <= '0;
    end else begin
      safe_m <= safe_in;
      safe_s <= safe_m;
      a_r    <= a_in;
      b_r    <= b_in;
      a_p    <= a_r;
      b_p    <= b_r;
    end
  end

  // Capture fires once, on the cycle the stable run length reaches SETTLE
  always_comb begin
    eq      = (a_r == a_p) && (b_r == b_p);
    capture = safe_s && eq && (stab == SW'(SETTLE - 1)) && (a_r != 32'd0) &&
              ({a_r, b_r} != {a_last, b_last});
    timeout = (tcnt == TW'(TIMEOUT_CYC - 1));
    drop    = capture || timeout;
  end

  // Stability run counter, saturating so it cannot wrap into a false capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab <= '0;
    end else if (safe_s && eq) begin
      if (stab != SW'(SETTLE)) stab <= stab + 1'b1;
    end else begin
      stab <= '0;
    end
  end

  // Last captured pair, updated even when the capture itself is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_last <= '0;
      b_last <= '0;
    end else if (capture) begin
      a_last <= a_r;
      b_last <= b_r;
    end
  end

  // Loss-of-signal timer: holds at its limit until IDLE can issue the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (capture || (state == ST_IDLE && timeout)) begin
      tcnt <= '0;
    end else if (!timeout) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign div_start = (state == ST_MUL);
  assign dividend  = (DW'(b_cap) * DW'(F_CLK_HZ)) << FRAC_BITS;
  assign q_sat     = (|quotient[DW-1:QW]) ? '1 : quotient[QW-1:0];
  assign busy      = (state != ST_IDLE);

  fm_divider #(.DW(DW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (a_cap),
    .quotient (quotient),
    .done     (div_done)
  );

  // Controller FSM; result outputs only change on entering OUT or on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_cap      <= '0;
      b_cap      <= '0;
      freq_q     <= '0;
      freq_valid <= 1'b0;
      no_signal  <= 1'b0;
      overrun    <= 1'b0;
      ovr_sticky <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            a_cap <= a_r;
            b_cap <= b_r;
            state <= ST_MUL;
          end else if (timeout) begin
            freq_q     <= '0;
            no_signal  <= 1'b1;
            overrun    <= ovr_sticky;
            ovr_sticky <= 1'b0;
            freq_valid <= 1'b1;
            state      <= ST_OUT;
          end
        end
        ST_MUL: begin
          if (drop) ovr_sticky <= 1'b1;
          state <= ST_DIV;
        end
        ST_DIV: begin
          if (div_done) begin
            freq_q     <= q_sat;
            no_signal  <= 1'b0;
            overrun    <= ovr_sticky;
            ovr_sticky <= drop;
            freq_valid <= 1'b1;
            state      <= ST_OUT;
          end else if (drop) begin
            ovr_sticky <= 1'b1;
          end
        end
        default: begin
          if (drop) ovr_sticky <= 1'b1;
          if (freq_ready) begin
            freq_valid <= 1'b0;
            overrun    <= 1'b0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
